// File: rtl/resp_log_buffer_if.sv
// Record-in / byte-out bus of the response log buffer, including its status outputs.
interface resp_log_buffer_if #(
    parameter int DEPTH = 64
);
    localparam int AW = $clog2(DEPTH);

    logic          rec_valid;
    logic [7:0]    rec_opcode;
    logic [7:0]    rec_result;
    logic          rec_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] pr;
    logic [AW:0]   count;
    logic          overflow;

    modport master (
        output rec_valid, rec_opcode, rec_result, out_ready,
        input  rec_ready, out_data, out_valid, pr, count, overflow
    );

    modport slave (
        input  rec_valid, rec_opcode, rec_result, out_ready,
        output rec_ready, out_data, out_valid, pr, count, overflow
    );
endinterface

// File: rtl/resp_log_buffer.sv
// Circular byte log of {opcode, result} records with a byte-wide pop port.
// Define RESP_LOG_OVERWRITE_EN to overwrite the oldest record instead of back-pressuring.
module resp_log_buffer #(
    parameter int DEPTH = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    resp_log_buffer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, WR_OP, WR_RES} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [7:0]    r_mem [DEPTH];
    logic [7:0]    r_op;
    logic [7:0]    r_res;
    logic [AW-1:0] r_pr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_space_ok;
    logic          w_rec_ready;
    logic          w_accept;
    logic          w_drop;
    logic          w_pop;
    logic          w_wr_en;
    logic [7:0]    w_wr_byte;

`ifdef RESP_LOG_OVERWRITE_EN
    assign w_space_ok = 1'b1;
    assign w_drop     = w_accept && (r_count > CW'(DEPTH - 2));
`else
    assign w_space_ok = (r_count <= CW'(DEPTH - 2));
    assign w_drop     = 1'b0;
`endif

    // Held low while reset is asserted, so it is only seen high once reset releases.
    assign w_rec_ready = (r_state == IDLE) && w_space_ok && !i_rst;
    assign w_accept    = bus.rec_valid && w_rec_ready;
    assign w_pop       = (r_count != '0) && bus.out_ready && !w_drop;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so every
            // register samples pre-edge values regardless of statement order.
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case, so no path leaves a
        // variable unassigned and no latch is inferred.
        w_state_next = r_state;
        w_wr_en      = 1'b0;
        w_wr_byte    = r_op;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = WR_OP;
                end
            end
            WR_OP: begin
                w_wr_en      = 1'b1;
                w_wr_byte    = r_op;
                w_state_next = WR_RES;
            end
            WR_RES: begin
                w_wr_en      = 1'b1;
                w_wr_byte    = r_res;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pr     <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_pr <= r_pr + AW'(1);
            end
            if (w_drop) begin
                r_rd_ptr <= r_rd_ptr + AW'(2);
            end else if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_wr_en) - CW'(w_pop) - (w_drop ? CW'(2) : CW'(0));
        end
    end

    // NOTE: the storage array and record latches carry no reset; their contents
    // are only ever observed through pointers and count, which do reset.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_op  <= bus.rec_opcode;
            r_res <= bus.rec_result;
        end
        if (w_wr_en) begin
            r_mem[r_pr] <= w_wr_byte;
        end
    end

`ifdef RESP_LOG_OVERWRITE_EN
    logic r_overflow;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign bus.overflow = r_overflow;
`else
    assign bus.overflow = 1'b0;
`endif

    assign bus.rec_ready = w_rec_ready;
    assign bus.out_data  = r_mem[r_rd_ptr];
    assign bus.out_valid = (r_count != '0);
    assign bus.pr        = r_pr;
    assign bus.count     = r_count;
endmodule
